// File: rtl/par16_bus_target.sv
// -----------------------------------------------------------------------------
// par16_bus_target
//   Responder end of a 16-bit multiplexed parallel bus driven by an external
//   initiator. The pad side is a registered tristate buffer: io_read is the
//   registered pin sample, io_write/io_write_enable drive the pad. Bus phases
//   (address latch, write strobe, read strobe) are decoded into a single-cycle
//   internal memory request port; read data is driven back onto the bus with
//   a setup cycle before enable and a turnaround gap after release.
//
// Ports
//   clock            system clock
//   reset            asynchronous, active-high reset
//   bus_ale          address latch enable (asynchronous, active high)
//   bus_wr_n         write strobe (asynchronous, active low)
//   bus_rd_n         read strobe (asynchronous, active low)
//   io_read [15:0]   registered pin data from the pad buffer
//   io_write [15:0]  data to the pad (pad registers it one cycle)
//   io_write_enable  pad output enable
//   mem_addr [15:0]  request address
//   mem_wdata [15:0] write data
//   mem_wen          one-cycle write pulse
//   mem_ren          one-cycle read pulse
//   mem_rdata [15:0] read data, valid with mem_rvalid
//   mem_rvalid       read response strobe
//   proto_err        one-cycle pulse on a bus protocol violation
// -----------------------------------------------------------------------------
module par16_bus_target #(
    parameter int SYNC_STAGES  = 2,
    parameter int TURN_CYCLES  = 1,
    parameter int ADDR_AUTOINC = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        bus_ale,
    input  logic        bus_wr_n,
    input  logic        bus_rd_n,
    input  logic [15:0] io_read,
    output logic [15:0] io_write,
    output logic        io_write_enable,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_wen,
    output logic        mem_ren,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        proto_err
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDRD    = 3'd1,
        ST_WR_HOLD  = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_RD_SETUP = 3'd4,
        ST_RD_DRIVE = 3'd5,
        ST_TURN     = 3'd6
    } state_t;

    localparam logic [7:0] TURN_LAST = 8'(TURN_CYCLES - 1);

    // Synchronizer chains; bit 0 is the first flop after the pin.
    logic [SYNC_STAGES-1:0] ale_sync_r;
    logic [SYNC_STAGES-1:0] wr_sync_r;
    logic [SYNC_STAGES-1:0] rd_sync_r;

    // Previous synchronized level and registered edge events.
    logic ale_prev_r, wr_prev_r, rd_prev_r;
    logic ale_rise_r, wr_fall_r, wr_rise_r, rd_fall_r, rd_rise_r;

    state_t      state_r, state_s;
    logic [7:0]  turn_cnt_r, turn_cnt_s;
    logic        discard_r, discard_s;

    logic [15:0] addr_s, wdata_s, iow_s, addr_next_s;
    logic        wen_s, ren_s, iowe_s, err_s, any_edge_s;

    assign addr_next_s = (ADDR_AUTOINC != 32'sd0) ? (mem_addr + 16'd1) : mem_addr;
    assign any_edge_s  = ale_rise_r | wr_fall_r | wr_rise_r | rd_fall_r | rd_rise_r;

    // Strobe synchronizers, reset to the bus idle levels.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ale_sync_r <= '0;
            wr_sync_r  <= '1;
            rd_sync_r  <= '1;
        end else begin
            ale_sync_r <= {ale_sync_r[SYNC_STAGES-2:0], bus_ale};
            wr_sync_r  <= {wr_sync_r[SYNC_STAGES-2:0], bus_wr_n};
            rd_sync_r  <= {rd_sync_r[SYNC_STAGES-2:0], bus_rd_n};
        end
    end

    // Edge detection; events are registered so the FSM sees them one clock
    // after the synchronized level changes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ale_prev_r <= 1'b0;
            wr_prev_r  <= 1'b1;
            rd_prev_r  <= 1'b1;
            ale_rise_r <= 1'b0;
            wr_fall_r  <= 1'b0;
            wr_rise_r  <= 1'b0;
            rd_fall_r  <= 1'b0;
            rd_rise_r  <= 1'b0;
        end else begin
            ale_prev_r <= ale_sync_r[SYNC_STAGES-1];
            wr_prev_r  <= wr_sync_r[SYNC_STAGES-1];
            rd_prev_r  <= rd_sync_r[SYNC_STAGES-1];
            ale_rise_r <= ale_sync_r[SYNC_STAGES-1] & ~ale_prev_r;
            wr_fall_r  <= ~wr_sync_r[SYNC_STAGES-1] & wr_prev_r;
            wr_rise_r  <= wr_sync_r[SYNC_STAGES-1] & ~wr_prev_r;
            rd_fall_r  <= ~rd_sync_r[SYNC_STAGES-1] & rd_prev_r;
            rd_rise_r  <= rd_sync_r[SYNC_STAGES-1] & ~rd_prev_r;
        end
    end

    // Next-state and next-output decode for the bus phase FSM.
    always_comb begin
        state_s    = state_r;
        turn_cnt_s = turn_cnt_r;
        addr_s     = mem_addr;
        wdata_s    = mem_wdata;
        iow_s      = io_write;
        iowe_s     = io_write_enable;
        wen_s      = 1'b0;
        ren_s      = 1'b0;
        err_s      = 1'b0;
        // A pending discard is consumed by the stale response whenever it shows up.
        discard_s  = discard_r & ~mem_rvalid;

        case (state_r)
            ST_IDLE: begin
                if (ale_rise_r) begin
                    addr_s  = io_read;
                    state_s = ST_ADDRD;
                end else begin
                    state_s = ST_IDLE;
                end
                // No address yet: any data strobe is a violation.
                if (wr_fall_r || rd_fall_r) begin
                    err_s = 1'b1;
                end else begin
                    err_s = 1'b0;
                end
            end

            ST_ADDRD: begin
                if (wr_fall_r && rd_fall_r) begin
                    err_s = 1'b1;
                end else if (ale_rise_r) begin
                    addr_s = io_read;
                    err_s  = wr_fall_r | rd_fall_r;
                end else if (wr_fall_r) begin
                    wdata_s = io_read;
                    wen_s   = 1'b1;
                    state_s = ST_WR_HOLD;
                end else if (rd_fall_r) begin
                    ren_s   = 1'b1;
                    state_s = ST_RD_WAIT;
                end else begin
                    state_s = ST_ADDRD;
                end
            end

            ST_WR_HOLD: begin
                if (wr_rise_r) begin
                    addr_s  = addr_next_s;
                    state_s = ST_ADDRD;
                end else begin
                    err_s = ale_rise_r | rd_fall_r;
                end
            end

            ST_RD_WAIT: begin
                if (rd_rise_r) begin
                    // Abort: a response that has not arrived yet must be dropped.
                    err_s     = 1'b1;
                    discard_s = ~mem_rvalid;
                    state_s   = ST_ADDRD;
                end else begin
                    err_s = ale_rise_r | wr_fall_r;
                    if (mem_rvalid && !discard_r) begin
                        iow_s   = mem_rdata;
                        state_s = ST_RD_SETUP;
                    end else begin
                        state_s = ST_RD_WAIT;
                    end
                end
            end

            ST_RD_SETUP: begin
                // io_write was loaded last cycle, so the pad register holds
                // valid data before the pin is enabled.
                if (rd_rise_r) begin
                    err_s   = 1'b1;
                    state_s = ST_ADDRD;
                end else begin
                    err_s   = ale_rise_r | wr_fall_r;
                    iowe_s  = 1'b1;
                    state_s = ST_RD_DRIVE;
                end
            end

            ST_RD_DRIVE: begin
                if (rd_rise_r) begin
                    iowe_s     = 1'b0;
                    addr_s     = addr_next_s;
                    turn_cnt_s = 8'd0;
                    state_s    = ST_TURN;
                end else begin
                    err_s = ale_rise_r | wr_fall_r;
                end
            end

            ST_TURN: begin
                err_s = any_edge_s;
                if (turn_cnt_r == TURN_LAST) begin
                    state_s = ST_ADDRD;
                end else begin
                    turn_cnt_s = turn_cnt_r + 8'd1;
                end
            end

            default: begin
                state_s = ST_IDLE;
                iowe_s  = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            turn_cnt_r      <= 8'd0;
            discard_r       <= 1'b0;
            mem_addr        <= 16'd0;
            mem_wdata       <= 16'd0;
            mem_wen         <= 1'b0;
            mem_ren         <= 1'b0;
            io_write        <= 16'd0;
            io_write_enable <= 1'b0;
            proto_err       <= 1'b0;
        end else begin
            state_r         <= state_s;
            turn_cnt_r      <= turn_cnt_s;
            discard_r       <= discard_s;
            mem_addr        <= addr_s;
            mem_wdata       <= wdata_s;
            mem_wen         <= wen_s;
            mem_ren         <= ren_s;
            io_write        <= iow_s;
            io_write_enable <= iowe_s;
            proto_err       <= err_s;
        end
    end

endmodule
